alu4_result_queue: RTL and testbench
====================================

// Module: alu4_result_queue
// PURPOSE
//  Downstream stage of the 4-bit ALU. Captures each ALU result nibble plus its carry
//  through a valid/ready handshake and buffers them in a small circular FIFO for the
//  output formatter or a host reader. Derives a zero flag per entry, tracks occupancy,
//  and raises a sticky flag when the producer tries to push while the queue is blocked.
// PARAMETERS
//  DEPTH  4  FIFO entries; power of two, >= 2
//  LW     3  level width; must equal clog2(DEPTH)+1
// PORTS
//  clk            in   1   system clock; all state changes on the rising edge
//  rst            in   1   synchronous reset, active-high
//  ena            in   1   1 = push/pop allowed; 0 = all state held, no handshakes complete
//  in_valid       in   1   producer has a result this cycle
//  in_ready       out  1   queue accepts: ena && !full (bypass extends this, see CONFIG)
//  in_result      in   4   ALU result nibble
//  in_carry       in   1   ALU carry/borrow bit
//  out_valid      out  1   head entry available: ena && !empty
//  out_ready      in   1   consumer takes head this cycle
//  out_result     out  4   head result; 4'h0 when !out_valid
//  out_carry      out  1   head carry; 0 when !out_valid
//  out_zero       out  1   out_valid && (out_result == 4'h0)
//  level          out  LW  number of stored entries, 0..DEPTH
//  overflow_seen  out  1   sticky: set when in_valid && ena && !in_ready
// BEHAVIOUR
//  - Reset: wr_ptr=rd_ptr=0, level=0, overflow_seen=0, so in_ready=ena, out_valid=0,
//    out_result=0, out_carry=0, out_zero=0. Storage contents are don't-care.
//  - Reset mid-operation: all entries are discarded in that cycle; rst wins over push/pop.
//  - push = in_valid && in_ready: write {in_carry,in_result} at wr_ptr, wr_ptr += 1.
//  - pop  = out_valid && out_ready: rd_ptr += 1. Head data is a combinational read of
//    mem[rd_ptr].
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. full = (level==DEPTH),
//    empty = (level==0).
//  - Level: push only +1; pop only -1; both or neither: unchanged.
//  - Latency: a pushed entry appears on out_* the cycle after the push edge (1 cycle).
//  - Full: in_ready=0, producer must hold data; a pop in the same cycle frees a slot,
//    and in_ready rises the next cycle (no same-cycle full pass-through).
//  - Empty: out_valid=0, out_ready ignored, level stays 0 (never underflows).
//  - Simultaneous push and pop when 0 < level < DEPTH: both occur, level unchanged.
//  - ena=0: in_ready=0, out_valid=0, pointers/level/flag frozen; contents retained and
//    visible again when ena returns to 1.
//  - overflow_seen is cleared only by rst.
//  - No FSM beyond the pointer/level registers. Combinational paths are from
//    in_* / out_ready to flags only, never to storage.
// CONFIGURATION
//  ALU4_RESQ_BYPASS_EN
//   defined:   when empty && ena && in_valid, drive out_valid=1 and out_result/out_carry
//              combinationally from in_*. in_ready stays 1. If out_ready=1 that cycle,
//              the entry is consumed without being stored: no pointer or level change.
//              Otherwise it is stored normally, so latency is 0 when the queue is empty.
//   undefined: no bypass; minimum latency is 1 cycle as above.
// TESTING
//  T1 reset: assert rst 2 cycles with in_valid=1 -> level=0, out_valid=0, out_*=0,
//     overflow_seen=0.
//  T2 fill/drain: push 4'h3/c0, 4'hA/c1, 4'h0/c0, 4'hF/c1 with out_ready=0 -> level=4,
//     in_ready=0. Then drain -> outputs in the same order, out_zero=1 only on the 4'h0 entry.
//  T3 overflow: with the queue full, in_valid=1 for 1 cycle -> overflow_seen=1, level
//     stays 4, entry not stored. Flag persists after a drain until rst.
//  T4 wrap: 10 push/pop pairs at level=2 -> level stays 2, FIFO order preserved across
//     pointer wrap.
//  T5 ena gating: level=2, ena=0 with in_valid=out_ready=1 for 3 cycles -> no change,
//     out_valid=0. ena=1 -> the same head reappears.
//  T6 bypass (BYPASS_EN): empty, push 4'h5/c1 with out_ready=1 -> out_valid=1,
//     out_result=4'h5 the same cycle, level stays 0. Without the macro: out_valid rises
//     next cycle.

Source files
------------

// File: rtl/alu4_result_queue_if.sv
// Result-queue handshake bundle: producer side (in_*) and consumer side (out_*).
// master = environment driving pushes and pops; slave = the queue itself.
//   in_valid/in_result/in_carry : producer -> queue
//   in_ready                    : queue -> producer
//   out_valid/out_result/out_carry/out_zero : queue -> consumer
//   out_ready                   : consumer -> queue
interface alu4_result_queue_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_result;
  logic       in_carry;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic       out_carry;
  logic       out_zero;

  modport master (
    output in_valid, in_result, in_carry, out_ready,
    input  in_ready, out_valid, out_result, out_carry, out_zero
  );

  modport slave (
    input  in_valid, in_result, in_carry, out_ready,
    output in_ready, out_valid, out_result, out_carry, out_zero
  );
endinterface

// File: rtl/alu4_result_queue.sv
// ALU result queue: circular FIFO of {carry,result} with zero flag, level and
// sticky overflow. Option macro ALU4_RESQ_BYPASS_EN enables empty-queue bypass.
//   clk, rst       : clock, synchronous active-high reset
//   ena            : 0 freezes all state and blocks both handshakes
//   q (slave)      : in_* push handshake, out_* pop handshake and head data
//   level          : stored entries 0..DEPTH
//   overflow_seen  : sticky, set on a push attempt while in_ready is low
module alu4_result_queue #(
  parameter int DEPTH = 4,
  parameter int LW    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  alu4_result_queue_if.slave  q,
  output logic [LW-1:0]       level,
  output logic                overflow_seen
);

  localparam int PW = $clog2(DEPTH);

  logic [4:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] cnt;
  logic          ovf;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          wr_en;
  logic          rd_en;
  logic          byp;
  logic          byp_take;
  logic [4:0]    head;

  assign full  = (cnt == LW'(DEPTH));
  assign empty = (cnt == '0);

  assign q.in_ready = ena && !full;
  assign push       = q.in_valid && q.in_ready;

`ifdef ALU4_RESQ_BYPASS_EN
  // Empty queue: present the incoming entry directly on the head.
  assign byp       = empty && ena && q.in_valid;
  assign byp_take  = byp && q.out_ready;
  assign q.out_valid = ena && (!empty || q.in_valid);
  assign head      = byp ? {q.in_carry, q.in_result}
                         : mem[rd_ptr];
`else
  assign byp       = 1'b0;
  assign byp_take  = 1'b0;
  assign q.out_valid = ena && !empty;
  assign head      = mem[rd_ptr];
`endif

  assign pop   = q.out_valid && q.out_ready;

  // A bypassed entry taken in the same cycle never touches storage.
  assign wr_en = push && !byp_take;
  assign rd_en = pop && !byp;

  assign q.out_result = q.out_valid ? head[3:0] : 4'h0;
  assign q.out_carry  = q.out_valid ? head[4]   : 1'b0;
  assign q.out_zero   = q.out_valid && (head[3:0] == 4'h0);

  assign level         = cnt;
  assign overflow_seen = ovf;

  // Storage has no reset; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {q.in_carry, q.in_result};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (q.in_valid && ena && !q.in_ready) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu4_result_queue.sv
// Directed bench for alu4_result_queue with a queue-based scoreboard.
// Each step drives inputs, checks every output against a small model, then clocks.
module tb_alu4_result_queue;

  localparam int DEPTH = 4;

`ifdef ALU4_RESQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [2:0] level;
  logic       overflow_seen;

  alu4_result_queue_if qif ();

  alu4_result_queue #(.DEPTH(4), .LW(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .ena           (ena),
    .q             (qif),
    .level         (level),
    .overflow_seen (overflow_seen)
  );

  always #5 clk = ~clk;

  int         errs   = 0;
  int         checks = 0;
  logic [4:0] sb [$];
  bit         movf   = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, check against the model, clock, update the model.
  task automatic cyc(input string tag, input bit iv, input logic [3:0] ir,
                     input bit ic, input bit ordy, input bit en);
    int         lvl;
    bit         e_ir;
    bit         e_byp;
    bit         e_ov;
    bit         e_push;
    bit         e_pop;
    logic [4:0] eh;
    qif.in_valid  = iv;
    qif.in_result = ir;
    qif.in_carry  = ic;
    qif.out_ready = ordy;
    ena           = en;
    #1;
    lvl    = sb.size();
    e_ir   = en && (lvl < DEPTH);
    e_push = iv && e_ir;
    e_byp  = BYP && (lvl == 0) && en && iv;
    e_ov   = en && ((lvl > 0) || e_byp);
    eh     = 5'h00;
    if (e_byp) eh = {ic, ir};
    else if (lvl > 0) eh = sb[0];
    if (!e_ov) eh = 5'h00;
    e_pop  = e_ov && ordy;
    chk({tag, ".level"}, 8'(level), 8'(lvl));
    chk({tag, ".ovf"}, 8'(overflow_seen), 8'(movf));
    chk({tag, ".in_ready"}, 8'(qif.in_ready), 8'(e_ir));
    chk({tag, ".out_valid"}, 8'(qif.out_valid), 8'(e_ov));
    chk({tag, ".out_result"}, 8'(qif.out_result), 8'(eh[3:0]));
    chk({tag, ".out_carry"}, 8'(qif.out_carry), 8'(eh[4]));
    chk({tag, ".out_zero"}, 8'(qif.out_zero),
        8'(e_ov && (eh[3:0] == 4'h0)));
    @(posedge clk);
    #1;
    if (!(e_byp && ordy)) begin
      if (e_pop) void'(sb.pop_front());
      if (e_push) sb.push_back({ic, ir});
    end
    if (iv && en && !e_ir) movf = 1'b1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    qif.in_valid  = 1'b1;
    qif.in_result = 4'h6;
    qif.in_carry  = 1'b1;
    qif.out_ready = 1'b0;
    ena           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    sb.delete();
    movf = 1'b0;
  endtask

  initial begin
    // T1 reset with in_valid held high
    do_reset();
    cyc("t1", 0, 4'h0, 0, 0, 1);

    // T2 fill then drain
    cyc("t2_push3", 1, 4'h3, 0, 0, 1);
    cyc("t2_pushA", 1, 4'hA, 1, 0, 1);
    cyc("t2_push0", 1, 4'h0, 0, 0, 1);
    cyc("t2_pushF", 1, 4'hF, 1, 0, 1);
    chk("t2_full_level", 8'(level), 8'd4);

    // T3 push attempt while full
    cyc("t3_ovf", 1, 4'h7, 0, 0, 1);
    chk("t3_ovf_set", 8'(overflow_seen), 8'd1);
    for (int i = 0; i < 4; i++) cyc("t2_drain", 0, 4'h0, 0, 1, 1);
    cyc("t3_after", 0, 4'h0, 0, 0, 1);
    chk("t3_sticky", 8'(overflow_seen), 8'd1);

    // T4 wrap at level 2
    cyc("t4_pre", 1, 4'h1, 0, 0, 1);
    cyc("t4_pre", 1, 4'h2, 1, 0, 1);
    for (int i = 0; i < 10; i++)
      cyc("t4_pair", 1, 4'(i + 4), 1'(i), 1, 1);
    chk("t4_level", 8'(level), 8'd2);

    // T5 ena gating
    for (int i = 0; i < 3; i++) cyc("t5_off", 1, 4'h9, 0, 1, 0);
    cyc("t5_on", 0, 4'h0, 0, 0, 1);
    cyc("t5_pop", 0, 4'h0, 0, 1, 1);
    cyc("t5_pop", 0, 4'h0, 0, 1, 1);

    // Reset mid-operation discards entries
    cyc("rm_push", 1, 4'hC, 0, 0, 1);
    cyc("rm_push", 1, 4'hD, 1, 0, 1);
    do_reset();
    cyc("rm_chk", 0, 4'h0, 0, 0, 1);

    // T6 push into an empty queue with out_ready high
    qif.in_valid  = 1'b1;
    qif.in_result = 4'h5;
    qif.in_carry  = 1'b1;
    qif.out_ready = 1'b1;
    ena           = 1'b1;
    #1;
    chk("t6_ov_same", 8'(qif.out_valid), 8'(BYP));
    cyc("t6_push", 1, 4'h5, 1, 1, 1);
    chk("t6_level", 8'(level), BYP ? 8'd0 : 8'd1);
    cyc("t6_next", 0, 4'h0, 0, 1, 1);
    cyc("t6_idle", 0, 4'h0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
